// File: rtl/button_debounce_pkg.sv
// Shared board-level constants and the debounce FSM state encoding.
package button_debounce_pkg;

   localparam int CLK_HZ      = 12_000_000;
   localparam int DEBOUNCE_MS = 1;
   localparam int LONG_MS     = 500;

   // Defaults derived from the board clock: 1 ms debounce, 0.5 s long press.
   localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEF_LONG_CYCLES     = (CLK_HZ / 1000) * LONG_MS;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous board input, with a selectable reset level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_p0;

   // Stage 0 catches the async input, stage 1 presents a settled value.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p0 <= RST_VAL;
         q       <= RST_VAL;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronize, debounce, and emit press/release/long-press
// pulses plus a wrapping press counter. All outputs are registered.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int COUNT_W         = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_pin,
   output logic               btn_level,
   output logic               btn_press,
   output logic               btn_release,
   output logic               btn_long,
   output logic [COUNT_W-1:0] press_count
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int LONG_W = $clog2(LONG_CYCLES + 1);

   // The wait-state entry sample counts as the first of DEBOUNCE_CYCLES samples,
   // so the transition happens when the counter already holds DEBOUNCE_CYCLES-2.
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [LONG_W-1:0] LONG_FIRE = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

   // Long-press counter stops at LONG_CYCLES so btn_long can only fire once per press.
   function automatic logic [LONG_W-1:0] sat_inc(input logic [LONG_W-1:0] v);
      return (v == LONG_MAX) ? v : v + LONG_W'(1);
   endfunction

   logic pressed_raw;
   logic pressed_s;

   state_t              state, state_n;
   logic [DEB_W-1:0]    deb_cnt, deb_cnt_n;
   logic [LONG_W-1:0]   long_cnt, long_cnt_n;
   logic                level_n, press_n, release_n, long_n;
   logic [COUNT_W-1:0]  count_n;

   // Normalise polarity so 1 always means pressed; reset level 0 is "released".
   assign pressed_raw = btn_pin ^ ACTIVE_LOW;

   sync_2ff #(
      .RST_VAL (1'b0)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pressed_raw),
      .q   (pressed_s)
   );

   // State, counters and all outputs are registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         deb_cnt     <= '0;
         long_cnt    <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
         press_count <= '0;
      end else begin
         state       <= state_n;
         deb_cnt     <= deb_cnt_n;
         long_cnt    <= long_cnt_n;
         btn_level   <= level_n;
         btn_press   <= press_n;
         btn_release <= release_n;
         btn_long    <= long_n;
         press_count <= count_n;
      end
   end

   // Next-state and next-output logic; pulses default low every cycle.
   always_comb begin
      state_n    = state;
      deb_cnt_n  = deb_cnt;
      long_cnt_n = long_cnt;
      level_n    = btn_level;
      press_n    = 1'b0;
      release_n  = 1'b0;
      long_n     = 1'b0;
      count_n    = press_count;
      case (state)
         ST_IDLE: begin
            if (pressed_s) begin
               state_n   = ST_PRESS_WAIT;
               deb_cnt_n = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!pressed_s) begin
               state_n = ST_IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_n = ST_PRESSED;
               level_n = 1'b1;
               press_n = 1'b1;
               count_n = press_count + COUNT_W'(1);
            end else begin
               deb_cnt_n = deb_cnt + DEB_W'(1);
            end
         end
         ST_PRESSED: begin
            if (pressed_s) begin
               long_cnt_n = sat_inc(long_cnt);
               long_n     = (long_cnt == LONG_FIRE);
            end else begin
               // long_cnt is kept so a bounce back to PRESSED cannot re-arm btn_long.
               state_n   = ST_RELEASE_WAIT;
               deb_cnt_n = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            if (pressed_s) begin
               state_n = ST_PRESSED;
            end else if (deb_cnt == DEB_LAST) begin
               state_n    = ST_IDLE;
               level_n    = 1'b0;
               release_n  = 1'b1;
               long_cnt_n = '0;
            end else begin
               deb_cnt_n = deb_cnt + DEB_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a run-length reference model predicts every
// pulse, a monitor compares DUT outputs at the falling edge, plus directed scenarios.
module tb_button_debounce;

   localparam int DEB = 4;
   localparam int LNG = 20;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          btn_pin = 1'b1;
   logic          btn_level, btn_press, btn_release, btn_long;
   logic [CW-1:0] press_count;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LNG),
      .ACTIVE_LOW      (1'b1),
      .COUNT_W         (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_pin     (btn_pin),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // mask bits: [0] press, [1] release, [2] long
   typedef struct {
      int            cyc;
      logic [2:0]    mask;
      logic [CW-1:0] cnt;
   } ev_t;
   ev_t evq[$];

   int n_press = 0, n_release = 0, n_long = 0;
   int last_press_cyc = -1, last_long_cyc = -1;
   int press_log[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model state: pressed level seen through two sample delays,
   // run length of samples disagreeing with the debounced level, held-time count.
   logic          m_d0 = 1'b0, m_d1 = 1'b0;
   logic          m_level = 1'b0, m_prev = 1'b0, m_long_done = 1'b0;
   int            m_run = 0, m_held = 0;
   logic [CW-1:0] m_count = '0;

   initial begin : ref_model
      logic       s;
      logic [2:0] mask;
      ev_t        e;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_d0 = 1'b0; m_d1 = 1'b0; m_level = 1'b0; m_prev = 1'b0;
            m_long_done = 1'b0; m_run = 0; m_held = 0; m_count = '0;
         end else begin
            s    = m_d1;
            m_d1 = m_d0;
            m_d0 = ~btn_pin;
            mask = 3'b000;
            // held time: consecutive pressed samples while the button counts as down
            if (m_level && s && m_prev && !m_long_done) begin
               m_held++;
               if (m_held == LNG) begin
                  mask[2]     = 1'b1;
                  m_long_done = 1'b1;
               end
            end
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == DEB) begin
               m_run   = 0;
               m_level = s;
               if (s) begin
                  m_count++;
                  mask[0] = 1'b1;
               end else begin
                  mask[1]     = 1'b1;
                  m_held      = 0;
                  m_long_done = 1'b0;
               end
            end
            m_prev = s;
            if (mask != 3'b000) begin
               e.cyc  = cyc;
               e.mask = mask;
               e.cnt  = m_count;
               evq.push_back(e);
            end
         end
      end
   end

   initial begin : monitor
      logic [2:0] dmask, emask;
      logic [CW-1:0] ecnt;
      ev_t e;
      forever begin
         @(negedge clk);
         dmask = {btn_long, btn_release, btn_press};
         emask = 3'b000;
         ecnt  = m_count;
         if (evq.size() > 0 && evq[0].cyc == cyc) begin
            e     = evq.pop_front();
            emask = e.mask;
            ecnt  = e.cnt;
         end
         chk("level", 32'(btn_level), 32'(m_level));
         chk("count", 32'(press_count), 32'(ecnt));
         if (dmask != 3'b000 || emask != 3'b000) chk("pulses", 32'(dmask), 32'(emask));
         if (btn_press === 1'b1) begin
            n_press++;
            last_press_cyc = cyc;
            press_log.push_back(int'(press_count));
         end
         if (btn_release === 1'b1) n_release++;
         if (btn_long === 1'b1) begin
            n_long++;
            last_long_cyc = cyc;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      btn_pin = v;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin : stimulus
      int c0, r0, l0, p0;
      int exp_seq[5];
      exp_seq = '{1, 2, 3, 0, 1};
      step();

      // 1: reset with pin released, then idle
      rst = 1'b1;
      hold(1'b1, 3);
      chk("rst_level", 32'(btn_level), 0);
      chk("rst_pulses", 32'({btn_long, btn_release, btn_press}), 0);
      chk("rst_count", 32'(press_count), 0);
      rst = 1'b0;
      hold(1'b1, 50);
      chk("idle_no_pulses", n_press + n_release + n_long, 0);

      // 2: clean press
      c0 = cyc;
      hold(1'b0, 10);
      chk("press_latency", last_press_cyc - c0, 6);
      chk("press_once", n_press, 1);
      chk("press_level", 32'(btn_level), 1);
      chk("press_count1", 32'(press_count), 1);

      // 3: short glitch, then bounce train settling pressed
      hold(1'b1, 12);
      hold(1'b0, 3);
      hold(1'b1, 10);
      chk("glitch_no_press", n_press, 1);
      chk("glitch_level", 32'(btn_level), 0);
      hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 1);
      hold(1'b0, 12);
      chk("bounce_one_press", n_press, 2);

      // 4: long hold, then bouncy release
      hold(1'b1, 12);
      l0 = n_long;
      hold(1'b0, 30);
      chk("long_once", n_long - l0, 1);
      chk("long_delay", last_long_cyc - last_press_cyc, 20);
      r0 = n_release;
      hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 15);
      chk("no_second_long", n_long - l0, 1);
      chk("one_release", n_release - r0, 1);

      // 5: wrap of press_count
      rst = 1'b1;
      hold(1'b1, 2);
      rst = 1'b0;
      press_log.delete();
      for (int i = 0; i < 5; i++) begin
         hold(1'b0, 8);
         hold(1'b1, 8);
      end
      chk("wrap_n", press_log.size(), 5);
      for (int i = 0; i < 5 && i < press_log.size(); i++) chk("wrap_seq", press_log[i], exp_seq[i]);

      // 6: reset mid PRESS_WAIT and mid PRESSED
      r0 = n_release;
      hold(1'b0, 4);
      rst = 1'b1;
      step();
      chk("rst_pw_level", 32'(btn_level), 0);
      chk("rst_pw_count", 32'(press_count), 0);
      rst = 1'b0;
      c0 = cyc;
      p0 = n_press;
      hold(1'b0, 10);
      chk("rst_pw_fresh_press", n_press - p0, 1);
      chk("rst_pw_latency", last_press_cyc - c0, 6);
      rst = 1'b1;
      hold(1'b0, 2);
      chk("rst_pr_outputs", 32'({btn_level, btn_long, btn_release, btn_press}), 0);
      chk("rst_pr_count", 32'(press_count), 0);
      rst = 1'b0;
      c0 = cyc;
      hold(1'b0, 10);
      chk("rst_pr_latency", last_press_cyc - c0, 6);
      chk("rst_no_release", n_release - r0, 0);

      // random bounce, holds and occasional resets against the model
      hold(1'b1, 12);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            hold(btn_pin, $urandom_range(1, 2));
            rst = 1'b0;
         end
         if ($urandom_range(0, 9) == 0) hold(1'($urandom_range(0, 1)), $urandom_range(18, 30));
         else hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
      end
      hold(1'b1, 15);
      chk("queue_drained", evq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
